// File: rtl/pipeline_scoreboard_if.sv
// Bundle of issue / retire / kill requests and the scoreboard status
// that travel between the Decode stage and the register scoreboard.
interface pipeline_scoreboard_if #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 2
);
    logic                    issue_valid;
    logic                    issue_we;
    logic [AW-1:0]           issue_rd;
    logic                    issue_long;
    logic [NUM_SRC*AW-1:0]   issue_rs;
    logic [NUM_SRC-1:0]      issue_rs_use;
    logic                    wb_valid;
    logic [AW-1:0]           wb_rd;
    logic                    kill_valid;
    logic [AW-1:0]           kill_rd;
    logic                    stall_o;
    logic [NUM_SRC-1:0]      src_busy_o;
    logic [2**AW-1:0]        busy_vec_o;
    logic [AW+CNT_W-1:0]     outstanding_o;
    logic                    quiet_o;
    logic                    err_o;

    // Pipeline side: raises requests, observes stall and status.
    modport master (
        output issue_valid, issue_we, issue_rd, issue_long, issue_rs, issue_rs_use,
        output wb_valid, wb_rd, kill_valid, kill_rd,
        input  stall_o, src_busy_o, busy_vec_o, outstanding_o, quiet_o, err_o
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_long, issue_rs, issue_rs_use,
        input  wb_valid, wb_rd, kill_valid, kill_rd,
        output stall_o, src_busy_o, busy_vec_o, outstanding_o, quiet_o, err_o
    );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register,
// remembers whether the newest one is non-forwardable, and stalls issue on
// non-forwardable RAW and on WAW hazards (counter full or long-latency overwrite).
// Register 0 is never tracked.
module pipeline_scoreboard #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_scoreboard_if.slave  sb
);
    localparam int              NREG    = 2**AW;
    localparam int              SW      = CNT_W + 1;
    localparam int              OW      = AW + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]   cnt_r [NREG];
    logic [NREG-1:0]    lng_r;
    logic [NREG-1:0]    busyVec_r;
    logic [OW-1:0]      outstanding_r;
    logic               quiet_r;
    logic               err_r;

    logic [CNT_W-1:0]   cntNext_s [NREG];
    logic [NREG-1:0]    lngNext_s;
    logic [NREG-1:0]    busyNext_s;
    logic [OW-1:0]      totalNext_s;
    logic               clampErr_s;
    logic [NUM_SRC-1:0] srcBusy_s;
    logic               wawStall_s;
    logic               stall_s;
    logic               accept_s;

    // Source hazards: a used source whose newest pending write cannot be forwarded.
    always_comb begin
        logic [AW-1:0] srcSel_s;
        srcSel_s  = {AW{1'b0}};
        srcBusy_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            srcSel_s     = sb.issue_rs[i*AW +: AW];
            srcBusy_s[i] = sb.issue_rs_use[i] & (srcSel_s != {AW{1'b0}}) &
                           (cnt_r[srcSel_s] != {CNT_W{1'b0}}) & lng_r[srcSel_s];
        end
    end

    // Destination hazards: counter saturated, or a long write overtaking a pending one.
    always_comb begin
        logic [CNT_W-1:0] rdCnt_s;
        rdCnt_s    = cnt_r[sb.issue_rd];
        wawStall_s = sb.issue_we & (sb.issue_rd != {AW{1'b0}}) &
                     ((rdCnt_s == CNT_MAX) | (sb.issue_long & (rdCnt_s != {CNT_W{1'b0}})));
        stall_s    = sb.issue_valid & ((|srcBusy_s) | wawStall_s);
        accept_s   = sb.issue_valid & ~stall_s;
    end

    // Next per-register count and long flag; retire/kill underflow clamps to zero and flags an error.
    always_comb begin
        logic          inc_s;
        logic [1:0]    dec_s;
        logic [SW-1:0] sum_s;
        inc_s         = 1'b0;
        dec_s         = 2'b00;
        sum_s         = {SW{1'b0}};
        clampErr_s    = 1'b0;
        totalNext_s   = {OW{1'b0}};
        cntNext_s[0]  = {CNT_W{1'b0}};
        lngNext_s     = {NREG{1'b0}};
        busyNext_s    = {NREG{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            inc_s = accept_s & sb.issue_we & (sb.issue_rd == AW'(r));
            dec_s = {1'b0, sb.wb_valid & (sb.wb_rd == AW'(r))} +
                    {1'b0, sb.kill_valid & (sb.kill_rd == AW'(r))};
            sum_s = {1'b0, cnt_r[r]} + SW'(inc_s);
            if (SW'(dec_s) > sum_s) begin
                cntNext_s[r] = {CNT_W{1'b0}};
                clampErr_s   = 1'b1;
            end else begin
                cntNext_s[r] = CNT_W'(sum_s - SW'(dec_s));
            end
            if (cntNext_s[r] == {CNT_W{1'b0}}) begin
                lngNext_s[r] = 1'b0;
            end else if (inc_s) begin
                // The older write stays the newest-long only if it is not the one retiring now.
                lngNext_s[r] = sb.issue_long | (lng_r[r] & (SW'(cnt_r[r]) != SW'(dec_s)));
            end else begin
                lngNext_s[r] = lng_r[r];
            end
            busyNext_s[r] = (cntNext_s[r] != {CNT_W{1'b0}});
            totalNext_s   = totalNext_s + OW'(cntNext_s[r]);
        end
    end

    // Scoreboard state and registered status; reset drops every pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= {CNT_W{1'b0}};
            end
            lng_r         <= {NREG{1'b0}};
            busyVec_r     <= {NREG{1'b0}};
            outstanding_r <= {OW{1'b0}};
            quiet_r       <= 1'b1;
            err_r         <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cntNext_s[r];
            end
            lng_r         <= lngNext_s;
            busyVec_r     <= busyNext_s;
            outstanding_r <= totalNext_s;
            quiet_r       <= (totalNext_s == {OW{1'b0}});
            err_r         <= err_r | clampErr_s;
        end
    end

    assign sb.stall_o       = stall_s;
    assign sb.src_busy_o    = srcBusy_s;
    assign sb.busy_vec_o    = busyVec_r;
    assign sb.outstanding_o = outstanding_r;
    assign sb.quiet_o       = quiet_r;
    assign sb.err_o         = err_r;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed scenarios with
// hand-derived expectations, then randomized traffic against a count-per-register model.
module tb_pipeline_scoreboard;
    localparam int AW = 5, NUM_SRC = 2, CNT_W = 2;
    localparam int NREG = 32, CMAX = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_scoreboard_if #(.AW(AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) sbIf();

    pipeline_scoreboard #(.AW(AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbIf)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: pending-write count and newest-is-long flag per register.
    int mCnt [NREG];
    bit mLng [NREG];
    bit mErr;

    function automatic void mClear();
        for (int r = 0; r < NREG; r++) begin
            mCnt[r] = 0;
            mLng[r] = 1'b0;
        end
        mErr = 1'b0;
    endfunction

    function automatic bit mSrcBusy(input int i);
        int s;
        s = (i == 0) ? int'(sbIf.issue_rs[4:0]) : int'(sbIf.issue_rs[9:5]);
        return sbIf.issue_rs_use[i] && s != 0 && mCnt[s] > 0 && mLng[s];
    endfunction

    function automatic bit mStall();
        int rd;
        bit waw;
        rd  = int'(sbIf.issue_rd);
        waw = sbIf.issue_we && rd != 0 &&
              (mCnt[rd] == CMAX || (sbIf.issue_long && mCnt[rd] > 0));
        return sbIf.issue_valid && (mSrcBusy(0) || mSrcBusy(1) || waw);
    endfunction

    function automatic logic [31:0] mBusy();
        logic [31:0] b;
        b = 32'd0;
        for (int r = 0; r < NREG; r++) b[r] = (mCnt[r] != 0);
        return b;
    endfunction

    function automatic int mTotal();
        int t;
        t = 0;
        for (int r = 0; r < NREG; r++) t += mCnt[r];
        return t;
    endfunction

    task automatic drive(input bit v, input bit we, input int rd, input bit lg,
                         input int rs0, input int rs1, input bit [1:0] use_,
                         input bit wbv, input int wbrd, input bit kv, input int krd);
        sbIf.issue_valid  = v;
        sbIf.issue_we     = we;
        sbIf.issue_rd     = 5'(rd);
        sbIf.issue_long   = lg;
        sbIf.issue_rs     = {5'(rs1), 5'(rs0)};
        sbIf.issue_rs_use = use_;
        sbIf.wb_valid     = wbv;
        sbIf.wb_rd        = 5'(wbrd);
        sbIf.kill_valid   = kv;
        sbIf.kill_rd      = 5'(krd);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        bit acc;
        acc = sbIf.issue_valid && !mStall();
        for (int r = 1; r < NREG; r++) begin
            int inc, dec, t;
            inc = (acc && sbIf.issue_we && int'(sbIf.issue_rd) == r) ? 1 : 0;
            dec = ((sbIf.wb_valid && int'(sbIf.wb_rd) == r) ? 1 : 0) +
                  ((sbIf.kill_valid && int'(sbIf.kill_rd) == r) ? 1 : 0);
            t = mCnt[r] + inc - dec;
            if (t < 0) begin
                mErr = 1'b1;
                t = 0;
            end
            if (t == 0) mLng[r] = 1'b0;
            else if (inc == 1) mLng[r] = sbIf.issue_long || (mLng[r] && mCnt[r] != dec);
            mCnt[r] = t;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        @(posedge clk);
        @(negedge clk);
        mClear();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++; if (sbIf.busy_vec_o !== 32'd0) $display("FAIL rst_busy got %h want 0", sbIf.busy_vec_o); else nPass++;
        nChecks++; if (sbIf.outstanding_o !== 7'd0) $display("FAIL rst_outst got %0d want 0", sbIf.outstanding_o); else nPass++;
        nChecks++; if (sbIf.quiet_o !== 1'b1) $display("FAIL rst_quiet got %b want 1", sbIf.quiet_o); else nPass++;
        nChecks++; if (sbIf.err_o !== 1'b0) $display("FAIL rst_err got %b want 0", sbIf.err_o); else nPass++;
        drive(1, 1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(1, 1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 11); tick();
        idle();
        nChecks++; if (sbIf.outstanding_o !== 7'd2) $display("FAIL pre_rst_outst got %0d want 2", sbIf.outstanding_o); else nPass++;
        nChecks++; if (sbIf.err_o !== 1'b1) $display("FAIL pre_rst_err got %b want 1", sbIf.err_o); else nPass++;
        reset = 1'b1;
        #1;
        nChecks++; if (sbIf.outstanding_o !== 7'd0) $display("FAIL async_rst_outst got %0d want 0", sbIf.outstanding_o); else nPass++;
        @(posedge clk);
        @(negedge clk);
        mClear();
        nChecks++; if (sbIf.busy_vec_o !== 32'd0) $display("FAIL midrst_busy got %h want 0", sbIf.busy_vec_o); else nPass++;
        nChecks++; if (sbIf.quiet_o !== 1'b1) $display("FAIL midrst_quiet got %b want 1", sbIf.quiet_o); else nPass++;
        nChecks++; if (sbIf.err_o !== 1'b0) $display("FAIL midrst_err got %b want 0", sbIf.err_o); else nPass++;
        reset = 1'b0;
    endtask

    task automatic test_long_raw();
        doReset();
        drive(1, 1, 8, 1, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        nChecks++; if (sbIf.busy_vec_o[8] !== 1'b1) $display("FAIL long_busy8 got %b want 1", sbIf.busy_vec_o[8]); else nPass++;
        drive(1, 1, 10, 0, 8, 0, 2'b01, 0, 0, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b1) $display("FAIL long_raw_stall got %b want 1", sbIf.stall_o); else nPass++;
        nChecks++; if (sbIf.src_busy_o !== 2'b01) $display("FAIL long_raw_srcbusy got %b want 01", sbIf.src_busy_o); else nPass++;
        tick();
        drive(1, 1, 10, 0, 8, 0, 2'b01, 1, 8, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b1) $display("FAIL long_wb_same_cycle_stall got %b want 1", sbIf.stall_o); else nPass++;
        tick();
        drive(1, 1, 10, 0, 8, 0, 2'b01, 0, 0, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b0) $display("FAIL long_released_stall got %b want 0", sbIf.stall_o); else nPass++;
        tick();
        idle();
        nChecks++; if (sbIf.busy_vec_o !== 32'h0000_0400) $display("FAIL long_after_busy got %h want 00000400", sbIf.busy_vec_o); else nPass++;
        nChecks++; if (sbIf.outstanding_o !== 7'd1) $display("FAIL long_after_outst got %0d want 1", sbIf.outstanding_o); else nPass++;
    endtask

    task automatic test_forward();
        doReset();
        drive(1, 1, 9, 0, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 9, 9, 2'b11, 0, 0, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b0) $display("FAIL fwd_stall got %b want 0", sbIf.stall_o); else nPass++;
        nChecks++; if (sbIf.src_busy_o !== 2'b00) $display("FAIL fwd_srcbusy got %b want 00", sbIf.src_busy_o); else nPass++;
        tick();
        idle();
        nChecks++; if (sbIf.busy_vec_o[9] !== 1'b1) $display("FAIL fwd_busy9 got %b want 1", sbIf.busy_vec_o[9]); else nPass++;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 1, 9, 0, 0); tick();
        idle();
        nChecks++; if (sbIf.busy_vec_o[9] !== 1'b0) $display("FAIL fwd_busy9_wb got %b want 0", sbIf.busy_vec_o[9]); else nPass++;
        nChecks++; if (sbIf.quiet_o !== 1'b1) $display("FAIL fwd_quiet got %b want 1", sbIf.quiet_o); else nPass++;
    endtask

    task automatic test_counter_full();
        doReset();
        repeat (3) begin
            drive(1, 1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0);
            tick();
        end
        idle();
        nChecks++; if (sbIf.outstanding_o !== 7'd3) $display("FAIL full_outst got %0d want 3", sbIf.outstanding_o); else nPass++;
        drive(1, 1, 3, 0, 0, 0, 2'b00, 1, 3, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b1) $display("FAIL full_stall_with_wb got %b want 1", sbIf.stall_o); else nPass++;
        tick();
        idle();
        nChecks++; if (sbIf.outstanding_o !== 7'd2) $display("FAIL full_after_wb_outst got %0d want 2", sbIf.outstanding_o); else nPass++;
        drive(1, 1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b0) $display("FAIL full_retry_stall got %b want 0", sbIf.stall_o); else nPass++;
        tick();
        idle();
        nChecks++; if (sbIf.outstanding_o !== 7'd3) $display("FAIL full_retry_outst got %0d want 3", sbIf.outstanding_o); else nPass++;
        nChecks++; if (sbIf.err_o !== 1'b0) $display("FAIL full_err got %b want 0", sbIf.err_o); else nPass++;
    endtask

    task automatic test_kill_wb();
        doReset();
        drive(1, 1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(1, 1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        idle();
        nChecks++; if (sbIf.outstanding_o !== 7'd2) $display("FAIL kill_pre_outst got %0d want 2", sbIf.outstanding_o); else nPass++;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 1, 4, 1, 4); tick();
        idle();
        nChecks++; if (sbIf.busy_vec_o !== 32'h0000_0080) $display("FAIL kill_busy got %h want 00000080", sbIf.busy_vec_o); else nPass++;
        nChecks++; if (sbIf.outstanding_o !== 7'd1) $display("FAIL kill_outst got %0d want 1", sbIf.outstanding_o); else nPass++;
        nChecks++; if (sbIf.err_o !== 1'b1) $display("FAIL kill_err got %b want 1", sbIf.err_o); else nPass++;
    endtask

    task automatic test_reg0_simul();
        doReset();
        drive(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        idle();
        nChecks++; if (sbIf.outstanding_o !== 7'd0) $display("FAIL r0_outst got %0d want 0", sbIf.outstanding_o); else nPass++;
        nChecks++; if (sbIf.quiet_o !== 1'b1) $display("FAIL r0_quiet got %b want 1", sbIf.quiet_o); else nPass++;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0); tick();
        idle();
        nChecks++; if (sbIf.err_o !== 1'b0) $display("FAIL r0_err got %b want 0", sbIf.err_o); else nPass++;
        nChecks++; if (sbIf.busy_vec_o !== 32'd0) $display("FAIL r0_busy got %h want 0", sbIf.busy_vec_o); else nPass++;
        drive(1, 1, 6, 1, 0, 0, 2'b00, 0, 0, 0, 0); tick();
        drive(1, 1, 6, 0, 0, 0, 2'b00, 1, 6, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b0) $display("FAIL simul_stall got %b want 0", sbIf.stall_o); else nPass++;
        tick();
        idle();
        nChecks++; if (sbIf.outstanding_o !== 7'd1) $display("FAIL simul_outst got %0d want 1", sbIf.outstanding_o); else nPass++;
        nChecks++; if (sbIf.busy_vec_o[6] !== 1'b1) $display("FAIL simul_busy6 got %b want 1", sbIf.busy_vec_o[6]); else nPass++;
        drive(1, 0, 0, 0, 6, 0, 2'b01, 0, 0, 0, 0);
        nChecks++; if (sbIf.stall_o !== 1'b0) $display("FAIL simul_lng_cleared_stall got %b want 0", sbIf.stall_o); else nPass++;
        tick();
        idle();
    endtask

    task automatic test_random();
        bit v, we, lg, wbv, kv;
        int rd, rs0, rs1, wr, kr;
        bit [1:0] use_;
        doReset();
        for (int n = 0; n < 600; n++) begin
            v    = ($urandom % 4) != 0;
            we   = $urandom % 2;
            rd   = $urandom % 8;
            lg   = ($urandom % 3) == 0;
            rs0  = $urandom % 8;
            rs1  = $urandom % 8;
            use_ = 2'($urandom % 4);
            wr   = 1 + ($urandom % 7);
            wbv  = (mCnt[wr] > 0) && ($urandom % 2 == 0);
            kv   = ($urandom % 25) == 0;
            kr   = $urandom % 8;
            drive(v, we, rd, lg, rs0, rs1, use_, wbv, wr, kv, kr);
            nChecks++; if (sbIf.stall_o !== mStall()) $display("FAIL rnd_stall cyc %0d got %b want %b", n, sbIf.stall_o, mStall()); else nPass++;
            nChecks++; if (sbIf.src_busy_o !== {mSrcBusy(1), mSrcBusy(0)}) $display("FAIL rnd_srcbusy cyc %0d got %b want %b%b", n, sbIf.src_busy_o, mSrcBusy(1), mSrcBusy(0)); else nPass++;
            tick();
            nChecks++; if (sbIf.busy_vec_o !== mBusy()) $display("FAIL rnd_busy cyc %0d got %h want %h", n, sbIf.busy_vec_o, mBusy()); else nPass++;
            nChecks++; if (sbIf.outstanding_o !== 7'(mTotal())) $display("FAIL rnd_outst cyc %0d got %0d want %0d", n, sbIf.outstanding_o, mTotal()); else nPass++;
            nChecks++; if (sbIf.quiet_o !== (mTotal() == 0)) $display("FAIL rnd_quiet cyc %0d got %b want %b", n, sbIf.quiet_o, mTotal() == 0); else nPass++;
            nChecks++; if (sbIf.err_o !== mErr) $display("FAIL rnd_err cyc %0d got %b want %b", n, sbIf.err_o, mErr); else nPass++;
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        mClear();
        idle();
        test_reset();
        test_long_raw();
        test_forward();
        test_counter_full();
        test_kill_wb();
        test_reg0_simul();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
